// File: rtl/delay_stream_reader_pkg.sv
// Shared types for the delay-line read side: FSM state encoding and a level helper.
// Ports: none (package only).
// Imported by delay_stream_reader and wrap_ptr_ctr.
package delay_stream_reader_pkg;

  // These encodings match the other ORB delay-line blocks, so a state value
  // seen on a debug bus decodes the same way for every block.
  typedef enum logic [1:0] {
    DSR_FILL   = 2'd0,
    DSR_STREAM = 2'd1,
    DSR_DRAIN  = 2'd2
  } dsr_state_e;

  // Returns 1 when the occupancy count has reached the lag threshold.
  // Occupancy is an unsigned count of B+1 bits, so a 32-bit compare is lossless.
  function automatic logic lvl_at_least(input int unsigned lvl, input int unsigned thr);
    return (lvl >= thr);
  endfunction

endpackage

// File: rtl/delay_stream_reader_wrap_ptr_ctr.sv
// Module wrap_ptr_ctr: B-bit circular pointer that advances by one when inc is set.
// Ports: clk, rst (sync, active-high), inc (advance), ptr (current pointer).
// The pointer wraps modulo 2**B through natural overflow; there is no terminal-count special case.
module wrap_ptr_ctr
  import delay_stream_reader_pkg::*;
#(
  parameter int B = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [B-1:0] ptr
);

  logic [B-1:0] ptr_q;
  logic [B-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = ptr_q + B'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/delay_stream_reader.sv
// Module delay_stream_reader: read side of a fixed-lag circular line buffer, with a D-sample lag,
//   downstream valid/ready back-pressure and an end-of-frame drain that flushes the buffered samples.
// Ports: clk, rst (sync, active-high); write side ena/dat_in/in_rdy; eof; read side
//   out_vld/out_rdy/dat_out; status level and full; ovf exists only when DELAY_RD_OVF_EN is defined.
// Optional feature macro: DELAY_RD_OVF_EN adds a sticky flag that records writes dropped because in_rdy was low.
module delay_stream_reader
  import delay_stream_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int D     = 593,
  parameter int B     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] dat_in,
  output logic             in_rdy,
  input  logic             eof,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] dat_out,
  output logic [B:0]       level,
  output logic             full
`ifdef DELAY_RD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int         DEPTH   = 1 << B;
  localparam logic [B:0] LVL_MAX = (B+1)'(DEPTH);

  logic [B-1:0] wr_ptr;
  logic [B-1:0] rd_ptr;
  logic [B:0]   level_q;
  logic [B:0]   level_d;
  dsr_state_e   state_q;
  dsr_state_e   state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic         wr_fire;
  logic         rd_fire;

  // in_rdy is built from registered state only, so out_rdy never reaches it combinationally.
  assign full    = (level_q == LVL_MAX);
  assign in_rdy  = !full && (state_q != DSR_DRAIN);
  assign level   = level_q;
  assign wr_fire = ena && in_rdy;
  assign rd_fire = out_vld && out_rdy;

  wrap_ptr_ctr #(.B(B)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_fire),
    .ptr (wr_ptr)
  );

  wrap_ptr_ctr #(.B(B)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_fire),
    .ptr (rd_ptr)
  );

  // RAM: written on the clock edge and read asynchronously at rd_ptr. Its contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr] <= dat_in;
    end
  end

  // Occupancy. A write needs !full and a read needs out_vld, which needs level > 0,
  // so the count stays within 0..2**B without explicit clamping.
  always_comb begin
    level_d = level_q;
    if (wr_fire && !rd_fire) begin
      level_d = level_q + (B+1)'(1);
    end else if (rd_fire && !wr_fire) begin
      level_d = level_q - (B+1)'(1);
    end
  end

  // Next-state logic. The FILL->STREAM test uses the level being loaded at this edge.
  // Streaming therefore begins in the first cycle that shows D samples held: each sample
  // leaves exactly D cycles after it was written, and level settles at D.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DSR_FILL: begin
        if (eof) begin
          state_d = DSR_DRAIN;
        end else if (lvl_at_least(32'(level_d), D)) begin
          state_d = DSR_STREAM;
        end
      end
      DSR_STREAM: begin
        if (eof) begin
          state_d = DSR_DRAIN;
        end
      end
      DSR_DRAIN: begin
        // eof is ignored here. Leave the cycle after the last sample has gone.
        if (level_q == '0) begin
          state_d = DSR_FILL;
        end
      end
      default: state_d = DSR_FILL;
    endcase
  end

  // Outputs. A reset cycle never presents valid data, so no read handshake completes while buffered data is discarded.
  always_comb begin
    out_vld = 1'b0;
    unique case (state_q)
      DSR_FILL:   out_vld = 1'b0;
      DSR_STREAM: out_vld = lvl_at_least(32'(level_q), D);
      DSR_DRAIN:  out_vld = (level_q != '0);
      default:    out_vld = 1'b0;
    endcase
    if (rst) begin
      out_vld = 1'b0;
    end
  end

  assign dat_out = out_vld ? mem_q[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DSR_FILL;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

`ifdef DELAY_RD_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Sticky: any write attempt refused by in_rdy sets the flag. Only reset clears it.
  always_comb begin
    ovf_d = ovf_q;
    if (ena && !in_rdy) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_delay_stream_reader.sv
module tb_delay_stream_reader;

  localparam int WIDTH = 8;
  localparam int D     = 4;
  localparam int B     = 3;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, ena, eof, out_rdy;
  logic [7:0] dat_in, dat_out;
  logic       in_rdy, out_vld, full;
  logic [3:0] level;
`ifdef DELAY_RD_OVF_EN
  logic       ovf;
`endif

  always #5 clk = ~clk;

  delay_stream_reader #(.WIDTH(WIDTH), .D(D), .B(B)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .dat_in  (dat_in),
    .in_rdy  (in_rdy),
    .eof     (eof),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .dat_out (dat_out),
    .level   (level),
    .full    (full)
`ifdef DELAY_RD_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  int n_chk;
  int n_pass;

  // Reference model: a FIFO queue plus a three-way mode (0 fill, 1 stream, 2 drain).
  logic [7:0] mq[$];
  int         mmode;
  bit         movf;
  logic       e_vld, e_in_rdy, e_full;
  logic [7:0] e_dat;
  int         e_lvl;

  // Values sampled from the DUT in the most recent cycle.
  logic       a_vld, a_in_rdy, a_full, a_ovf, a_fire;
  logic [7:0] a_dat;
  logic [3:0] a_lvl;

  typedef struct packed {
    logic       e;
    logic [7:0] d;
    logic       f;
    logic       r;
    logic       x_vld;
    logic [7:0] x_dat;
    logic [3:0] x_lvl;
    logic       x_full;
    logic       x_in_rdy;
  } vec_t;

  vec_t tbl[8];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end else begin
      n_pass++;
    end
  endfunction

  function automatic void model_outputs();
    e_lvl    = mq.size();
    e_full   = (e_lvl == DEPTH);
    e_in_rdy = !e_full && (mmode != 2);
    case (mmode)
      1:       e_vld = (e_lvl >= D);
      2:       e_vld = (e_lvl != 0);
      default: e_vld = 1'b0;
    endcase
    e_dat = e_vld ? mq[0] : 8'd0;
  endfunction

  function automatic void model_step(logic e, logic [7:0] d, logic f, logic r, logic rs);
    int old;
    if (rs) begin
      mq.delete();
      mmode = 0;
      movf  = 1'b0;
    end else begin
      old = mq.size();
      if (e && !e_in_rdy) movf = 1'b1;
      if (e_vld && r) void'(mq.pop_front());
      if (e && e_in_rdy) mq.push_back(d);
      case (mmode)
        0: begin
          if (f) mmode = 2;
          else if (mq.size() >= D) mmode = 1;
        end
        1: if (f) mmode = 2;
        default: if (old == 0) mmode = 0;
      endcase
    end
  endfunction

  task automatic apply(input logic e, input logic [7:0] d, input logic f, input logic r,
                       input logic rs, input bit cmp);
    ena = e; dat_in = d; eof = f; out_rdy = r; rst = rs;
    @(negedge clk);
    model_outputs();
    a_vld = out_vld; a_dat = dat_out; a_lvl = level; a_full = full; a_in_rdy = in_rdy;
    a_fire = out_vld && r && !rs;
`ifdef DELAY_RD_OVF_EN
    a_ovf = ovf;
`else
    a_ovf = 1'b0;
`endif
    if (cmp && !rs) begin
      chk("m_out_vld", 32'(a_vld), 32'(e_vld));
      chk("m_dat_out", 32'(a_dat), 32'(e_dat));
      chk("m_level", 32'(a_lvl), 32'(e_lvl));
      chk("m_full", 32'(a_full), 32'(e_full));
      chk("m_in_rdy", 32'(a_in_rdy), 32'(e_in_rdy));
`ifdef DELAY_RD_OVF_EN
      chk("m_ovf", 32'(a_ovf), 32'(movf));
`endif
    end
    @(posedge clk);
    #1;
    model_step(e, d, f, r, rs);
  endtask

  task automatic do_reset();
    apply(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int fires;
    n_chk = 0;
    n_pass = 0;
    mmode = 0;
    movf = 1'b0;

    // Case 1 vectors: {ena, dat, eof, rdy, exp vld, exp dat, exp level, exp full, exp in_rdy}
    tbl[0] = '{1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 8'd0, 4'd1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 8'd0, 4'd2, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 8'd0, 4'd3, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'd5, 1'b0, 1'b1, 1'b1, 8'd1, 4'd4, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'd6, 1'b0, 1'b1, 1'b1, 8'd2, 4'd4, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd3, 4'd4, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 4'd3, 1'b0, 1'b1};

    do_reset();
    do_reset();

    // Case 1: table-driven streaming start. Row 0 also checks the reset state.
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].e, tbl[i].d, tbl[i].f, tbl[i].r, 1'b0, 1'b1);
      chk($sformatf("t1_vld[%0d]", i), 32'(a_vld), 32'(tbl[i].x_vld));
      chk($sformatf("t1_dat[%0d]", i), 32'(a_dat), 32'(tbl[i].x_dat));
      chk($sformatf("t1_lvl[%0d]", i), 32'(a_lvl), 32'(tbl[i].x_lvl));
      chk($sformatf("t1_full[%0d]", i), 32'(a_full), 32'(tbl[i].x_full));
      chk($sformatf("t1_inrdy[%0d]", i), 32'(a_in_rdy), 32'(tbl[i].x_in_rdy));
    end

    // Case 2: stall the consumer until full, drop one write, then read 1..8 in order.
    do_reset();
    for (int k = 1; k <= 8; k++) apply(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_full", 32'(a_full), 32'd1);
    chk("t2_in_rdy", 32'(a_in_rdy), 32'd0);
    chk("t2_level_full", 32'(a_lvl), 32'd8);
    apply(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_level_after_drop", 32'(a_lvl), 32'd8);
    for (int k = 0; k < 8; k++) begin
      apply(1'b1, 8'(10 + k), 1'b0, 1'b1, 1'b0, 1'b1);
      chk($sformatf("t2_read[%0d]", k), 32'(a_dat), 32'(k + 1));
    end

    // Case 3: six samples buffered, then eof drains all six.
    do_reset();
    for (int k = 1; k <= 6; k++) apply(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b1);
    fires = 0;
    apply(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    if (a_fire) fires++;
    chk("t3_first", 32'(a_dat), 32'd1);
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      if (a_fire) fires++;
      chk($sformatf("t3_drain_dat[%0d]", k), 32'(a_dat), 32'(k + 2));
      chk($sformatf("t3_drain_inrdy[%0d]", k), 32'(a_in_rdy), 32'd0);
    end
    apply(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    if (a_fire) fires++;
    chk("t3_empty_level", 32'(a_lvl), 32'd0);
    chk("t3_empty_inrdy", 32'(a_in_rdy), 32'd0);
    chk("t3_empty_vld", 32'(a_vld), 32'd0);
    apply(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t3_back_to_fill", 32'(a_in_rdy), 32'd1);
    chk("t3_fire_count", 32'(fires), 32'd6);

    // Case 4: simultaneous write and read keep level at D while both pointers wrap.
    do_reset();
    for (int k = 1; k <= 4; k++) apply(1'b1, 8'(k), 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      apply(1'b1, 8'(5 + k), 1'b0, 1'b1, 1'b0, 1'b1);
      chk($sformatf("t4_level[%0d]", k), 32'(a_lvl), 32'd4);
      chk($sformatf("t4_dat[%0d]", k), 32'(a_dat), 32'(k + 1));
    end

    // Case 5: reset while streaming discards the buffered data.
    do_reset();
    for (int k = 1; k <= 5; k++) apply(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_vld", 32'(a_vld), 32'd0);
    chk("t5_dat", 32'(a_dat), 32'd0);
    chk("t5_level", 32'(a_lvl), 32'd0);
    chk("t5_in_rdy", 32'(a_in_rdy), 32'd1);
    chk("t5_full", 32'(a_full), 32'd0);

    // Case 6: write while full, then drain, then reset.
    do_reset();
    for (int k = 1; k <= 8; k++) apply(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_level", 32'(a_lvl), 32'd8);
`ifdef DELAY_RD_OVF_EN
    chk("t6_ovf_set", 32'(a_ovf), 32'd1);
`endif
    apply(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) apply(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t6_drained", 32'(a_lvl), 32'd0);
`ifdef DELAY_RD_OVF_EN
    chk("t6_ovf_held", 32'(a_ovf), 32'd1);
`endif
    do_reset();
    apply(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef DELAY_RD_OVF_EN
    chk("t6_ovf_cleared", 32'(a_ovf), 32'd0);
`endif

    // Randomized traffic compared against the queue model every cycle.
    for (int c = 0; c < 1500; c++) begin
      logic r_rst, r_ena, r_eof, r_rdy;
      r_rst = ($urandom_range(0, 199) == 0);
      r_eof = ($urandom_range(0, 39) == 0);
      r_ena = ($urandom_range(0, 9) < 7);
      r_rdy = ($urandom_range(0, 9) < 6);
      apply(r_ena, 8'($urandom), r_eof, r_rdy, r_rst, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
